div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider for the execute stage; serves DIV/DIVU.
//  Started by the decoded divide control (mulOrdivE, mdIsSignE); holds the pipeline via stall_o.
//  Delivers the quotient and remainder as a hi/lo pair for the HILO write path in mem stage.
// PARAMETERS
//  WIDTH  32  operand width; the iteration count equals WIDTH
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      reset, asynchronous, active-low
//  start_i    in   1      divide request from execute stage (mulOrdivE & divide op)
//  signed_i   in   1      1 = DIV (two's complement), 0 = DIVU (mdIsSignE)
//  annul_i    in   1      flushE: abandon any operation in progress
//  a_i        in   WIDTH  dividend (rs value after forwarding)
//  b_i        in   WIDTH  divisor (rt value after forwarding)
//  stall_o    out  1      request to stall F/D/E stages while divide is pending
//  done_o     out  1      one-cycle pulse; hi_o/lo_o valid this cycle
//  hi_o       out  WIDTH  remainder
//  lo_o       out  WIDTH  quotient
// BEHAVIOUR
//  Reset (rst=0, asynchronous): state IDLE, done_o=0, hi_o=0, lo_o=0, counters and working registers 0.
//  stall_o = (IDLE & start_i & ~annul_i) | BUSY. Combinational; low in IDLE when no start; low in DONE.
//  FSM has three states: IDLE, BUSY, DONE.
//   IDLE -> BUSY when start_i & ~annul_i.
//     Latch magnitudes |a|, |b| (absolute value only if signed_i).
//     Latch sign_q = signed_i & (a[MSB]^b[MSB]) and sign_r = signed_i & a[MSB].
//     Clear cnt.
//   BUSY: one restoring step per cycle.
//     Shift {rem,quo} left 1; trial = rem - |b|; if non-negative, rem=trial and quo[0]=1.
//     cnt++. After WIDTH steps -> DONE.
//   DONE (1 cycle): done_o=1; hi_o/lo_o registered at BUSY->DONE edge. Then -> IDLE.
//     New start_i sampled in DONE is ignored; it is accepted in the following IDLE cycle.
//  Latency: start accepted in cycle N.
//     stall_o high cycles N..N+WIDTH; done_o high in N+WIDTH+1.
//     Hence 33 cycles of stall for WIDTH=32.
//  Operands are captured at acceptance; later changes to a_i/b_i/signed_i are ignored.
//  Sign fix (applied at BUSY->DONE): lo_o = sign_q ? -quo : quo; hi_o = sign_r ? -rem : rem.
//  Overflow: signed 0x80000000 / -1 gives lo_o=0x80000000, hi_o=0; no exception, natural wrap.
//  Divide by zero: lo_o = all ones, hi_o = a_i as latched.
//     Sign fix is bypassed; no exception; full latency still applies.
//  annul_i:
//     In BUSY or DONE: next state IDLE, done_o forced 0 that cycle, hi_o/lo_o unchanged.
//     With start_i in IDLE: start is ignored (annul wins).
//  hi_o/lo_o hold their last values until the next completed divide.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//     At acceptance, if |b| > |a| or |a|==0, FSM goes IDLE -> DONE directly.
//     Result lo_o=0, hi_o=a_i as latched.
//     stall_o is high for cycle N only; done_o is high in N+1.
//     Divide by zero never takes the early-out path.
//  DIV_EARLY_OUT_EN undefined: every divide takes the full WIDTH+1 cycle latency.
// STRUCTURE
//  Shared package div_pkg holds:
//     state encoding constants DIV_IDLE=2'd0, DIV_BUSY=2'd1, DIV_DONE=2'd2
//     the counter width function clog2(WIDTH+1)
//  One natural sub-module: div_step, a combinational single restoring iteration.
//     Inputs: rem, quo, divisor. Outputs: next rem, next quo.
//  Top level holds the FSM, counter, operand/sign latches and output registers.
// TESTING
//  DIVU 7/2: start cycle 0, stall cycles 0..32 -> done_o at cycle 33, lo_o=3, hi_o=1.
//  DIV -7/2 (a=0xFFFFFFF9) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
//     Also DIV 7/-2 -> lo_o=0xFFFFFFFD, hi_o=1.
//  DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
//     DIVU 5/0 -> lo_o=0xFFFFFFFF, hi_o=5; latency 33.
//  Start 100/7, assert annul_i at cycle 10:
//     stall_o low at cycle 11, no done_o, hi_o/lo_o unchanged.
//     Then start 9/3 at cycle 12 -> done_o at cycle 45, lo_o=3, hi_o=0.
//  Assert rst low at cycle 20 of a divide:
//     outputs 0 immediately, state IDLE.
//     A start issued after release completes normally.
//  With DIV_EARLY_OUT_EN: DIVU 3/10 -> done_o at cycle 1, lo_o=0, hi_o=3.
//     Same stimulus without the macro -> done_o at cycle 33, identical result.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 restoring divider: state encoding and
// the helper used to size the iteration counter.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic int clog2(input int value);
    int bits;
    int rest;
    bits = 0;
    rest = value - 1;
    while (rest > 0) begin
      bits++;
      rest = rest >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the divider.
// The slave side is the divider; the master side is the pipeline.
interface div_if #(parameter int WIDTH = 32);

  logic             start_i;
  logic             signed_i;
  logic             annul_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, signed_i, annul_i, a_i, b_i,
    input  stall_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, a_i, b_i,
    output stall_o, done_o, hi_o, lo_o
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring iteration: shift {rem,quo} left, subtract the
// divisor from the partial remainder and keep the difference if non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The partial remainder stays below the divisor, so WIDTH+1 bits hold the
  // shifted value and the top bit of the difference is its sign.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, div_i};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: WIDTH restoring steps, remainder on hi, quotient on lo.
// Optional DIV_EARLY_OUT_EN skips the iterations when the quotient is trivially zero.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  div_if.slave bus
);

  localparam int CNT_W = clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign a_mag = (bus.signed_i && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
  assign b_mag = (bus.signed_i && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;

  assign bus.stall_o = ((state_q == DIV_IDLE) && bus.start_i && !bus.annul_i) ||
                       (state_q == DIV_BUSY);
  assign bus.done_o  = done_q && !bus.annul_i;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    a_d       = a_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          a_d       = bus.a_i;
          div_d     = b_mag;
          quo_d     = a_mag;
          rem_d     = '0;
          cnt_d     = '0;
          quo_neg_d = bus.signed_i && (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
          rem_neg_d = bus.signed_i && bus.a_i[WIDTH-1];
          state_d   = DIV_BUSY;
`ifdef DIV_EARLY_OUT_EN
          // Quotient is zero and the remainder is the raw dividend.
          if ((b_mag != '0) && ((b_mag > a_mag) || (a_mag == '0))) begin
            state_d = DIV_DONE;
            lo_d    = '0;
            hi_d    = bus.a_i;
            done_d  = 1'b1;
          end
`endif
        end
      end
      DIV_BUSY: begin
        if (bus.annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DIV_DONE;
            done_d  = 1'b1;
            // A zero divisor reports all-ones and the untouched dividend.
            if (div_q == '0) begin
              lo_d = '1;
              hi_d = a_q;
            end else begin
              lo_d = quo_neg_q ? -step_quo : step_quo;
              hi_d = rem_neg_q ? -step_rem : step_rem;
            end
          end
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      a_q       <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      a_q       <= a_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random divides
// against an arithmetic reference model; honours DIV_EARLY_OUT_EN when defined.
module tb_div_unit;

  logic clk;
  logic rst;

  int assert_count = 0;
  int fail_count   = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  div_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Plain signed/unsigned arithmetic, with the zero-divisor and overflow cases.
  function automatic void refDivide(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                    output logic [31:0] q, output logic [31:0] r, output logic early);
    longint sa;
    longint sb;
    longint mag_a;
    longint mag_b;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
    mag_a = (sa < 0) ? -sa : sa;
    mag_b = (sb < 0) ? -sb : sb;
`ifdef DIV_EARLY_OUT_EN
    early = (b != 32'd0) && ((mag_b > mag_a) || (mag_a == 0));
`else
    early = 1'b0 && (mag_b > mag_a);
`endif
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn, input string tag);
    logic [31:0] exp_q, exp_r, got_hi, got_lo;
    logic        early;
    int          stall_cycles, done_cycle, exp_lat;
    refDivide(a, b, sgn, exp_q, exp_r, early);
    exp_lat      = early ? 1 : 33;
    stall_cycles = 0;
    done_cycle   = -1;
    got_hi       = '0;
    got_lo       = '0;
    @(posedge clk); #1;
    bus.start_i  = 1'b1;
    bus.a_i      = a;
    bus.b_i      = b;
    bus.signed_i = sgn;
    for (int c = 0; c < 80 && done_cycle < 0; c++) begin
      @(negedge clk);
      if (bus.stall_o) stall_cycles++;
      if (bus.done_o) begin
        done_cycle = c;
        got_hi     = bus.hi_o;
        got_lo     = bus.lo_o;
      end
      @(posedge clk); #1;
      bus.start_i  = 1'b0;
      bus.a_i      = $urandom;
      bus.b_i      = $urandom;
      bus.signed_i = 1'($urandom_range(0, 1));
    end
    checkOutput({tag, "_lat"},   64'(done_cycle),   64'(exp_lat));
    checkOutput({tag, "_stall"}, 64'(stall_cycles), 64'(exp_lat));
    checkOutput({tag, "_lo"},    64'(got_lo),       64'(exp_q));
    checkOutput({tag, "_hi"},    64'(got_hi),       64'(exp_r));
    last_hi = exp_r;
    last_lo = exp_q;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          done_seen;
    rst          = 1'b0;
    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.annul_i  = 1'b0;
    bus.a_i      = '0;
    bus.b_i      = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_done",  64'(bus.done_o),  64'd0);
    checkOutput("reset_stall", 64'(bus.stall_o), 64'd0);
    checkOutput("reset_hi",    64'(bus.hi_o),    64'd0);
    checkOutput("reset_lo",    64'(bus.lo_o),    64'd0);
    rst = 1'b1;

    applyStimulus(32'd7,          32'd2,          1'b0, "divu_7_2");
    applyStimulus(32'hFFFF_FFF9,  32'd2,          1'b1, "div_m7_2");
    applyStimulus(32'd7,          32'hFFFF_FFFE,  1'b1, "div_7_m2");
    applyStimulus(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, "div_ovf");
    applyStimulus(32'd5,          32'd0,          1'b0, "divu_5_0");
    applyStimulus(32'hFFFF_FFFB,  32'd0,          1'b1, "div_m5_0");
    applyStimulus(32'd3,          32'd10,         1'b0, "divu_3_10");
    applyStimulus(32'hFFFF_FFFD,  32'd10,         1'b1, "div_m3_10");
    applyStimulus(32'd0,          32'd9,          1'b0, "divu_0_9");

    // Results hold while idle.
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("hold_hi", 64'(bus.hi_o), 64'(last_hi));
    checkOutput("hold_lo", 64'(bus.lo_o), 64'(last_lo));

    // Annul in BUSY at cycle 10, restart at cycle 12.
    applyStimulus(32'd1000, 32'd7, 1'b0, "pre_annul");
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.a_i = 32'd100; bus.b_i = 32'd7; bus.signed_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; bus.start_i = 1'b0; end
    bus.annul_i = 1'b1;
    @(negedge clk);
    checkOutput("annul_busy_stall", 64'(bus.stall_o), 64'd1);
    checkOutput("annul_busy_done",  64'(bus.done_o),  64'd0);
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    @(negedge clk);
    checkOutput("annul_after_stall", 64'(bus.stall_o), 64'd0);
    checkOutput("annul_after_done",  64'(bus.done_o),  64'd0);
    checkOutput("annul_after_hi",    64'(bus.hi_o),    64'(last_hi));
    checkOutput("annul_after_lo",    64'(bus.lo_o),    64'(last_lo));
    applyStimulus(32'd9, 32'd3, 1'b0, "post_annul");

    // Start together with annul in IDLE is dropped.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.annul_i = 1'b1; bus.a_i = 32'd50; bus.b_i = 32'd5;
    @(negedge clk);
    checkOutput("annul_idle_stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done_o || bus.stall_o) done_seen++;
    end
    checkOutput("annul_idle_quiet", 64'(done_seen), 64'd0);

    // Annul in DONE suppresses the pulse; results were already registered.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.a_i = 32'd100; bus.b_i = 32'd7; bus.signed_i = 1'b0;
    repeat (33) begin @(posedge clk); #1; bus.start_i = 1'b0; end
    bus.annul_i = 1'b1;
    @(negedge clk);
    checkOutput("annul_done_pulse", 64'(bus.done_o), 64'd0);
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    @(negedge clk);
    checkOutput("annul_done_idle", 64'(bus.stall_o), 64'd0);
    checkOutput("annul_done_lo",   64'(bus.lo_o),    64'd14);
    checkOutput("annul_done_hi",   64'(bus.hi_o),    64'd2);

    // Asynchronous reset in the middle of a divide.
    applyStimulus(32'd1234, 32'd10, 1'b0, "pre_reset");
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.a_i = 32'd77; bus.b_i = 32'd4; bus.signed_i = 1'b0;
    repeat (20) begin @(posedge clk); #1; bus.start_i = 1'b0; end
    rst = 1'b0;
    #1;
    checkOutput("midrst_hi",    64'(bus.hi_o),    64'd0);
    checkOutput("midrst_lo",    64'(bus.lo_o),    64'd0);
    checkOutput("midrst_done",  64'(bus.done_o),  64'd0);
    checkOutput("midrst_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(32'd77, 32'd4, 1'b0, "post_reset");

    // Random operands, biased toward the interesting corners.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: rb = 32'($urandom_range(1, 15));
        1: rb = 32'd0;
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 20));
        default: ;
      endcase
      applyStimulus(ra, rb, rs, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
